pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller_pkg.sv | 25 ++
 rtl/pipeline_hazard_controller.sv | 155 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller_pkg
// Purpose  : Shared execution-unit encodings and hazard-controller FSM state
//            type. The forwarding unit imports the same definitions.
// Contents : EX_ALU / EX_MEM / EX_MDU unit-select codes, mdu_state_t.
// Revision : 1.0  initial release
// ============================================================================
package pipeline_hazard_controller_pkg;

   // Execution-unit select carried alongside each instruction.
   localparam logic [1:0] EX_ALU = 2'd0;
   localparam logic [1:0] EX_MEM = 2'd1;
   localparam logic [1:0] EX_MDU = 2'd2;

   // Width of the inline MDU countdown (covers MDU_LATENCY up to 15).
   localparam int MDU_CNT_WIDTH = 4;

   typedef enum logic {
      IDLE     = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_t;

endpackage : pipeline_hazard_controller_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : Decode-stage interlock. Detects load-use hazards against the
//            execute stage and tracks a single in-flight multiply/divide
//            operation (RAW, WAW and structural hazards), producing stall,
//            bubble and issue controls for the pipeline.
// Ports    : clk, rst_n (async, active low)
//            flush                     - kill decode-stage instruction
//            dec_*                     - decode-stage instruction fields
//            exec_*                    - execute-stage destination feedback
//            stall / bubble / issue    - pipeline controls (combinational)
//            mdu_busy / mdu_dest / mdu_done - MDU scoreboard state
//            stall_cycles[31:0]        - saturating stall counter, present
//                                        only with HAZARD_PERF_COUNTER_EN
// Config   : `define HAZARD_PERF_COUNTER_EN to add the stall_cycles port.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MDU_LATENCY    = 4
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    dec_valid,
   input  logic                    dec_rs_enable,
   input  logic                    dec_rt_enable,
   input  logic [REG_ADDR_WIDTH:0] dec_prs_addr,
   input  logic [REG_ADDR_WIDTH:0] dec_prt_addr,
   input  logic                    dec_wb_reg,
   input  logic [REG_ADDR_WIDTH:0] dec_write_addr,
   input  logic [1:0]              dec_exec_src,
   input  logic                    exec_wb_reg,
   input  logic [1:0]              exec_exec_src,
   input  logic [REG_ADDR_WIDTH:0] exec_write_addr,
   output logic                    stall,
   output logic                    bubble,
   output logic                    issue,
   output logic                    mdu_busy,
   output logic [REG_ADDR_WIDTH:0] mdu_dest,
`ifdef HAZARD_PERF_COUNTER_EN
   output logic [31:0]             stall_cycles,
`endif
   output logic                    mdu_done
);

   localparam logic [MDU_CNT_WIDTH-1:0] CNT_LOAD = MDU_CNT_WIDTH'(MDU_LATENCY - 1);

   mdu_state_t                 state_q, state_d;
   logic [MDU_CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [REG_ADDR_WIDTH:0]    dest_q, dest_d;

   logic rs_live, rt_live;
   logic load_use, mdu_hazard, mdu_start;

   // Physical register 0 is hardwired, so it never participates in a hazard.
   assign rs_live = dec_rs_enable && (dec_prs_addr != '0);
   assign rt_live = dec_rt_enable && (dec_prt_addr != '0);

   assign mdu_busy = (state_q == MDU_BUSY);
   assign mdu_done = mdu_busy && (cnt_q == '0);
   assign mdu_dest = dest_q;

   // ------------------------------------------------------------------
   // Hazard detection and pipeline controls
   // ------------------------------------------------------------------
   always_comb begin
      load_use   = 1'b0;
      mdu_hazard = 1'b0;

      // Load data is not available until the memory stage; one bubble lets
      // the forwarding path take over on the following cycle.
      if (dec_valid && exec_wb_reg && (exec_exec_src == EX_MEM)) begin
         load_use = (rs_live && (dec_prs_addr == exec_write_addr)) ||
                    (rt_live && (dec_prt_addr == exec_write_addr));
      end

      // While the MDU is busy: RAW on its result, WAW on its destination,
      // and structural conflict for any further MDU instruction.
      if (dec_valid && mdu_busy) begin
         mdu_hazard = (rs_live && (dec_prs_addr == dest_q)) ||
                      (rt_live && (dec_prt_addr == dest_q)) ||
                      (dec_wb_reg && (dec_write_addr != '0) &&
                       (dec_write_addr == dest_q)) ||
                      (dec_exec_src == EX_MDU);
      end
   end

   assign stall     = (load_use || mdu_hazard) && !flush;
   assign bubble    = stall || flush;
   assign issue     = dec_valid && !stall && !flush;
   assign mdu_start = issue && (dec_exec_src == EX_MDU) && dec_wb_reg;

   // ------------------------------------------------------------------
   // MDU scoreboard FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dest_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dest_q  <= dest_d;
      end
   end

   // flush is deliberately absent here: an issued MDU operation runs to
   // completion regardless of what happens in decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dest_d  = dest_q;
      unique case (state_q)
         IDLE: begin
            if (mdu_start) begin
               state_d = MDU_BUSY;
               cnt_d   = CNT_LOAD;
               dest_d  = dec_write_addr;
            end
         end
         MDU_BUSY: begin
            // The terminal count cycle is the completion cycle; the
            // dependent instruction issues on the next one.
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef HAZARD_PERF_COUNTER_EN
   // ------------------------------------------------------------------
   // Saturating stall-cycle counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule : pipeline_hazard_controller
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Purpose  : Directed self-checking bench for pipeline_hazard_controller
//            (REG_ADDR_WIDTH=5, MDU_LATENCY=4). Inputs change on the falling
//            edge; outputs are sampled 1 ns later, clear of the rising edge.
// Config   : honours HAZARD_PERF_COUNTER_EN for the stall_cycles port.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_controller;
   import pipeline_hazard_controller_pkg::*;

   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          dec_valid, dec_rs_enable, dec_rt_enable;
   logic [AW-1:0] dec_prs_addr, dec_prt_addr;
   logic          dec_wb_reg;
   logic [AW-1:0] dec_write_addr;
   logic [1:0]    dec_exec_src;
   logic          exec_wb_reg;
   logic [1:0]    exec_exec_src;
   logic [AW-1:0] exec_write_addr;
   logic          stall, bubble, issue, mdu_busy, mdu_done;
   logic [AW-1:0] mdu_dest;
`ifdef HAZARD_PERF_COUNTER_EN
   logic [31:0]   stall_cycles;
`endif

   int checks     = 0;
   int errors     = 0;
   int exp_stalls = 0;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(
      .REG_ADDR_WIDTH (5),
      .MDU_LATENCY    (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (flush),
      .dec_valid       (dec_valid),
      .dec_rs_enable   (dec_rs_enable),
      .dec_rt_enable   (dec_rt_enable),
      .dec_prs_addr    (dec_prs_addr),
      .dec_prt_addr    (dec_prt_addr),
      .dec_wb_reg      (dec_wb_reg),
      .dec_write_addr  (dec_write_addr),
      .dec_exec_src    (dec_exec_src),
      .exec_wb_reg     (exec_wb_reg),
      .exec_exec_src   (exec_exec_src),
      .exec_write_addr (exec_write_addr),
      .stall           (stall),
      .bubble          (bubble),
      .issue           (issue),
      .mdu_busy        (mdu_busy),
      .mdu_dest        (mdu_dest),
`ifdef HAZARD_PERF_COUNTER_EN
      .stall_cycles    (stall_cycles),
`endif
      .mdu_done        (mdu_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Stall check that also accumulates the expected stall-cycle count;
   // called once for every cycle in which stall is expected high.
   task automatic chk_stall(input string tag, input logic exp);
      chk(tag, {31'd0, stall}, {31'd0, exp});
      if (exp) exp_stalls++;
   endtask

   task automatic set_dec(input logic v, input logic rse, input logic [AW-1:0] rs,
                          input logic rte, input logic [AW-1:0] rt,
                          input logic wb, input logic [AW-1:0] wa, input logic [1:0] src);
      dec_valid      = v;
      dec_rs_enable  = rse;
      dec_prs_addr   = rs;
      dec_rt_enable  = rte;
      dec_prt_addr   = rt;
      dec_wb_reg     = wb;
      dec_write_addr = wa;
      dec_exec_src   = src;
   endtask

   task automatic set_exec(input logic wb, input logic [1:0] src, input logic [AW-1:0] wa);
      exec_wb_reg     = wb;
      exec_exec_src   = src;
      exec_write_addr = wa;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      set_dec(0, 0, 0, 0, 0, 0, 0, EX_ALU);
      set_exec(0, EX_ALU, 0);

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy",   {31'd0, mdu_busy}, 32'd0);
      chk("rst_done",   {31'd0, mdu_done}, 32'd0);
      chk("rst_dest",   {26'd0, mdu_dest}, 32'd0);
      chk_stall("rst_stall", 1'b0);
      chk("rst_bubble", {31'd0, bubble}, 32'd0);
      chk("rst_issue",  {31'd0, issue},  32'd0);
`ifdef HAZARD_PERF_COUNTER_EN
      chk("rst_perf", stall_cycles, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- load-use on rs (p7) ----------------
      @(negedge clk);
      set_exec(1, EX_MEM, 7);
      set_dec(1, 1, 7, 0, 0, 0, 0, EX_ALU);
      #1;
      chk_stall("lu_rs_stall", 1'b1);
      chk("lu_rs_bubble", {31'd0, bubble}, 32'd1);
      chk("lu_rs_issue",  {31'd0, issue},  32'd0);
      @(negedge clk);
      set_exec(0, EX_ALU, 0);                 // load moved on, bubble in exec
      #1;
      chk_stall("lu_rs_after_stall", 1'b0);
      chk("lu_rs_after_issue",  {31'd0, issue},  32'd1);
      chk("lu_rs_after_bubble", {31'd0, bubble}, 32'd0);

      // ---------------- load-use on rt ----------------
      @(negedge clk);
      set_exec(1, EX_MEM, 7);
      set_dec(1, 0, 0, 1, 7, 0, 0, EX_ALU);
      #1;
      chk_stall("lu_rt_stall", 1'b1);
      @(negedge clk);
      set_exec(0, EX_ALU, 0);
      #1;
      chk("lu_rt_after_issue", {31'd0, issue}, 32'd1);

      // ---------------- p0 never hazards ----------------
      @(negedge clk);
      set_exec(1, EX_MEM, 0);
      set_dec(1, 1, 0, 1, 0, 0, 0, EX_ALU);
      #1;
      chk_stall("p0_stall", 1'b0);
      chk("p0_issue", {31'd0, issue}, 32'd1);

      // ---------------- disabled sources ----------------
      @(negedge clk);
      set_exec(1, EX_MEM, 7);
      set_dec(1, 0, 7, 0, 7, 0, 0, EX_ALU);
      #1;
      chk_stall("dis_src_stall", 1'b0);
      chk("dis_src_issue", {31'd0, issue}, 32'd1);

      // ---------------- ALU producer in exec: forwarded, no stall ----------------
      @(negedge clk);
      set_exec(1, EX_ALU, 7);
      set_dec(1, 1, 7, 0, 0, 0, 0, EX_ALU);
      #1;
      chk_stall("alu_prod_stall", 1'b0);

      // ---------------- load-use with flush ----------------
      @(negedge clk);
      set_exec(1, EX_MEM, 7);
      set_dec(1, 1, 7, 0, 0, 0, 0, EX_ALU);
      flush = 1'b1;
      #1;
      chk_stall("flush_stall", 1'b0);
      chk("flush_bubble", {31'd0, bubble}, 32'd1);
      chk("flush_issue",  {31'd0, issue},  32'd0);

      // ---------------- MDU op without writeback stays idle ----------------
      @(negedge clk);
      flush = 1'b0;
      set_exec(0, EX_ALU, 0);
      set_dec(1, 0, 0, 0, 0, 0, 9, EX_MDU);
      #1;
      chk("nowb_issue", {31'd0, issue}, 32'd1);
      @(negedge clk);
      set_dec(1, 1, 9, 0, 0, 0, 0, EX_ALU);
      #1;
      chk("nowb_busy", {31'd0, mdu_busy}, 32'd0);
      chk_stall("nowb_stall", 1'b0);

      // ---------------- MUL p9 then dependent read ----------------
      @(negedge clk);
      set_dec(1, 0, 0, 0, 0, 1, 9, EX_MDU);
      #1;
      chk("mul_issue", {31'd0, issue},    32'd1);
      chk("mul_busy0", {31'd0, mdu_busy}, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         set_dec(1, 1, 9, 0, 0, 0, 0, EX_ALU);
         #1;
         chk_stall($sformatf("raw_stall_c%0d", i), 1'b1);
         chk($sformatf("raw_busy_c%0d", i),  {31'd0, mdu_busy}, 32'd1);
         chk($sformatf("raw_dest_c%0d", i),  {26'd0, mdu_dest}, 32'd9);
         chk($sformatf("raw_done_c%0d", i),  {31'd0, mdu_done}, (i == 4) ? 32'd1 : 32'd0);
         chk($sformatf("raw_issue_c%0d", i), {31'd0, issue},    32'd0);
      end
      @(negedge clk);
      #1;
      chk_stall("raw_c5_stall", 1'b0);
      chk("raw_c5_issue", {31'd0, issue},    32'd1);
      chk("raw_c5_busy",  {31'd0, mdu_busy}, 32'd0);
      chk("raw_c5_done",  {31'd0, mdu_done}, 32'd0);

      // ---------------- WAW / independent / structural / flush-in-flight ----------------
      @(negedge clk);
      set_dec(1, 0, 0, 0, 0, 1, 9, EX_MDU);
      #1;
      chk("mul2_issue", {31'd0, issue}, 32'd1);
      @(negedge clk);
      set_dec(1, 0, 0, 0, 0, 1, 9, EX_ALU);   // counter 3
      #1;
      chk_stall("waw_stall", 1'b1);
      @(negedge clk);
      set_dec(1, 0, 0, 0, 0, 1, 3, EX_ALU);   // counter 2
      #1;
      chk_stall("indep_stall", 1'b0);
      chk("indep_issue", {31'd0, issue},    32'd1);
      chk("indep_busy",  {31'd0, mdu_busy}, 32'd1);
      @(negedge clk);
      set_dec(1, 0, 0, 0, 0, 1, 4, EX_MDU);   // counter 1
      #1;
      chk_stall("struct_stall", 1'b1);
      @(negedge clk);
      flush = 1'b1;                            // counter 0
      #1;
      chk_stall("fl_busy_stall", 1'b0);
      chk("fl_busy_bubble", {31'd0, bubble},   32'd1);
      chk("fl_busy_issue",  {31'd0, issue},    32'd0);
      chk("fl_busy_busy",   {31'd0, mdu_busy}, 32'd1);
      chk("fl_busy_done",   {31'd0, mdu_done}, 32'd1);
      @(negedge clk);
      flush = 1'b0;
      set_dec(0, 0, 0, 0, 0, 0, 0, EX_ALU);
      #1;
      chk("fl_after_busy", {31'd0, mdu_busy}, 32'd0);
      chk("fl_after_done", {31'd0, mdu_done}, 32'd0);
`ifdef HAZARD_PERF_COUNTER_EN
      chk("perf_count", stall_cycles, exp_stalls);
`endif

      // ---------------- reset mid-MDU at counter 2 ----------------
      @(negedge clk);
      set_dec(1, 0, 0, 0, 0, 1, 9, EX_MDU);
      #1;
      chk("mul3_issue", {31'd0, issue}, 32'd1);
      @(negedge clk);
      set_dec(1, 1, 9, 0, 0, 0, 0, EX_ALU);   // counter 3
      #1;
      chk_stall("mul3_stall", 1'b1);
      @(negedge clk);
      set_dec(0, 0, 0, 0, 0, 0, 0, EX_ALU);   // counter 2
      #1;
      chk("mul3_busy", {31'd0, mdu_busy}, 32'd1);
      #1;
      rst_n = 1'b0;
      exp_stalls = 0;
      #1;
      chk("arst_busy", {31'd0, mdu_busy}, 32'd0);
      chk("arst_done", {31'd0, mdu_done}, 32'd0);
      chk("arst_dest", {26'd0, mdu_dest}, 32'd0);
`ifdef HAZARD_PERF_COUNTER_EN
      chk("arst_perf", stall_cycles, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("post_rst_done_%0d", i), {31'd0, mdu_done}, 32'd0);
         chk($sformatf("post_rst_busy_%0d", i), {31'd0, mdu_busy}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pipeline_hazard_controller
`default_nettype wire
